// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite responder over a bank of 32-bit registers; B/R are returned 1 cycle after the last address/data handshake.
// Backpressure: one outstanding write and one outstanding read; AW/W/AR stay closed while the matching response waits.
module axi4lite_reg_slave #(
  parameter int                 P_ADDR_W  = 12,
  parameter int                 P_NREGS   = 16,
  parameter logic [P_NREGS-1:0] P_RO_MASK = '0,
  parameter logic [31:0]        P_RST_VAL = 32'h0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [P_ADDR_W-1:0]     s_awaddr,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [31:0]             s_wdata,
  input  logic [3:0]              s_wstrb,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  input  logic [P_ADDR_W-1:0]     s_araddr,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [31:0]             s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic [32*P_NREGS-1:0]   o_regs,
  input  logic [32*P_NREGS-1:0]   i_ro_data,
  output logic [P_NREGS-1:0]      o_wr_pulse,
  output logic [P_NREGS-1:0]      o_rd_pulse
);

  localparam int LP_IW = P_ADDR_W - 2;
  localparam logic [1:0] LP_OKAY   = 2'b00;
  localparam logic [1:0] LP_SLVERR = 2'b10;

  logic             r_aw_held, r_w_held;
  logic [LP_IW-1:0] r_aw_idx;
  logic [31:0]      r_w_data;
  logic [3:0]       r_w_strb;
  logic             r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]       r_bresp, r_rresp;
  logic [31:0]      r_rdata;
  logic [31:0]      r_regs [P_NREGS];
  logic [P_NREGS-1:0] r_wr_pulse, r_rd_pulse;

  logic             w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic             w_aw_held_nx, w_w_held_nx, w_bvalid_nx, w_rvalid_nx;
  logic [LP_IW-1:0] w_wr_idx, w_rd_idx;
  logic [31:0]      w_wr_data, w_rd_data;
  logic [3:0]       w_wr_strb;
  logic             w_wr_ok, w_rd_ok;
  logic [P_NREGS-1:0] w_wr_sel, w_rd_sel;
  logic             w_unused_addr_lsbs;

  assign w_unused_addr_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};

  assign w_aw_hs   = s_awvalid & r_awready;
  assign w_w_hs    = s_wvalid & r_wready;
  assign w_ar_hs   = s_arvalid & r_arready;
  assign w_wr_idx  = w_aw_hs ? s_awaddr[P_ADDR_W-1:2] : r_aw_idx;
  assign w_wr_data = w_w_hs ? s_wdata : r_w_data;
  assign w_wr_strb = w_w_hs ? s_wstrb : r_w_strb;
  assign w_rd_idx  = s_araddr[P_ADDR_W-1:2];
  assign w_wr_ok   = 32'(w_wr_idx) < P_NREGS;
  assign w_rd_ok   = 32'(w_rd_idx) < P_NREGS;

  // Commit as soon as both halves are either already held or handshaking this edge.
  assign w_commit     = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
  assign w_aw_held_nx = (r_aw_held | w_aw_hs) & ~w_commit;
  assign w_w_held_nx  = (r_w_held | w_w_hs) & ~w_commit;
  assign w_bvalid_nx  = w_commit | (r_bvalid & ~s_bready);
  assign w_rvalid_nx  = w_ar_hs | (r_rvalid & ~s_rready);

  always_comb begin
    w_rd_data = '0;
    w_rd_sel  = '0;
    w_wr_sel  = '0;
    for (int i = 0; i < P_NREGS; i++) begin
      if (w_rd_idx == LP_IW'(i)) begin
        w_rd_data   = P_RO_MASK[i] ? i_ro_data[32*i +: 32] : r_regs[i];
        w_rd_sel[i] = 1'b1;
      end
      if (w_wr_idx == LP_IW'(i) && !P_RO_MASK[i])
        w_wr_sel[i] = w_commit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_aw_idx   <= '0;
      r_w_data   <= '0;
      r_w_strb   <= '0;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= LP_OKAY;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rresp    <= LP_OKAY;
      r_rdata    <= '0;
      r_wr_pulse <= '0;
      r_rd_pulse <= '0;
    end else begin
      r_aw_held  <= w_aw_held_nx;
      r_w_held   <= w_w_held_nx;
      if (w_aw_hs) r_aw_idx <= s_awaddr[P_ADDR_W-1:2];
      if (w_w_hs) begin
        r_w_data <= s_wdata;
        r_w_strb <= s_wstrb;
      end
      r_awready  <= ~w_aw_held_nx & ~w_bvalid_nx;
      r_wready   <= ~w_w_held_nx & ~w_bvalid_nx;
      r_bvalid   <= w_bvalid_nx;
      if (w_commit) r_bresp <= w_wr_ok ? LP_OKAY : LP_SLVERR;
      // arready re-opens only after rvalid has dropped, capping reads at one per two cycles.
      r_arready  <= ~w_rvalid_nx;
      r_rvalid   <= w_rvalid_nx;
      if (w_ar_hs) begin
        r_rresp <= w_rd_ok ? LP_OKAY : LP_SLVERR;
        r_rdata <= w_rd_ok ? w_rd_data : 32'h0;
      end
      r_wr_pulse <= w_wr_sel;
      r_rd_pulse <= w_ar_hs ? w_rd_sel : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < P_NREGS; i++) r_regs[i] <= P_RST_VAL;
    end else begin
      for (int i = 0; i < P_NREGS; i++)
        if (w_wr_sel[i])
          for (int b = 0; b < 4; b++)
            if (w_wr_strb[b]) r_regs[i][8*b +: 8] <= w_wr_data[8*b +: 8];
    end
  end

  always_comb begin
    o_regs = '0;
    for (int i = 0; i < P_NREGS; i++) o_regs[32*i +: 32] = r_regs[i];
  end

  assign s_awready  = r_awready;
  assign s_wready   = r_wready;
  assign s_bvalid   = r_bvalid;
  assign s_bresp    = r_bresp;
  assign s_arready  = r_arready;
  assign s_rvalid   = r_rvalid;
  assign s_rresp    = r_rresp;
  assign s_rdata    = r_rdata;
  assign o_wr_pulse = r_wr_pulse;
  assign o_rd_pulse = r_rd_pulse;

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Directed bench for axi4lite_reg_slave: 16 slots, slot 15 read-only, non-zero reset value.
module tb_axi4lite_reg_slave;

  localparam int          AW  = 12;
  localparam int          NR  = 16;
  localparam logic [31:0] RV  = 32'hDEAD_0001;
  localparam logic [15:0] ROM = 16'h8000;

  logic            clk = 1'b0;
  logic            reset;
  logic [AW-1:0]   s_awaddr, s_araddr;
  logic            s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic            s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0]     s_wdata, s_rdata;
  logic [3:0]      s_wstrb;
  logic [1:0]      s_bresp, s_rresp;
  logic [32*NR-1:0] o_regs, i_ro_data;
  logic [NR-1:0]   o_wr_pulse, o_rd_pulse;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_regs [NR];

  always #5 clk = ~clk;

  axi4lite_reg_slave #(.P_ADDR_W(AW), .P_NREGS(NR), .P_RO_MASK(ROM), .P_RST_VAL(RV)) dut (
    .clk(clk), .reset(reset),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .o_regs(o_regs), .i_ro_data(i_ro_data), .o_wr_pulse(o_wr_pulse), .o_rd_pulse(o_rd_pulse)
  );

  function automatic logic [32*NR-1:0] exp_vec();
    logic [32*NR-1:0] v;
    for (int i = 0; i < NR; i++) v[32*i +: 32] = exp_regs[i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp, output logic [NR-1:0] pulses);
    int n;
    logic a, w;
    pulses = '0;
    s_awaddr = addr; s_awvalid = 1'b1;
    s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1;
    n = 0;
    while ((s_awvalid || s_wvalid) && n < 20) begin
      a = s_awready; w = s_wready;
      tick(); n++;
      if (a) s_awvalid = 1'b0;
      if (w) s_wvalid = 1'b0;
      pulses |= o_wr_pulse;
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    s_bready = 1'b1; n = 0;
    while (!s_bvalid && n < 20) begin tick(); n++; pulses |= o_wr_pulse; end
    checks++;
    if (!s_bvalid) begin errors++; $display("FAIL write_timeout addr=%h bvalid=%b required 1", addr, s_bvalid); end
    resp = s_bresp;
    tick(); pulses |= o_wr_pulse;
    s_bready = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] addr, output logic [31:0] data, output logic [1:0] resp,
                         output logic [NR-1:0] pulses);
    int n;
    pulses = '0;
    s_araddr = addr; s_arvalid = 1'b1; n = 0;
    while (!s_arready && n < 20) begin tick(); n++; end
    tick(); pulses |= o_rd_pulse;
    s_arvalid = 1'b0; n = 0;
    while (!s_rvalid && n < 20) begin tick(); n++; pulses |= o_rd_pulse; end
    checks++;
    if (!s_rvalid) begin errors++; $display("FAIL read_timeout addr=%h rvalid=%b required 1", addr, s_rvalid); end
    data = s_rdata; resp = s_rresp;
    s_rready = 1'b1;
    tick(); pulses |= o_rd_pulse;
    s_rready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; logic [NR-1:0] p; logic [31:0] e;
    reset = 1'b1;
    s_awvalid = 0; s_wvalid = 0; s_bready = 0; s_arvalid = 0; s_rready = 0;
    s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
    for (int i = 0; i < NR; i++) begin
      i_ro_data[32*i +: 32] = 32'hC0DE_0000 + 32'(i);
      exp_regs[i] = RV;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 5'b0) begin errors++;
      $display("FAIL rst_handshake got=%b required 00000", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid}); end
    checks++;
    if ({s_bresp, s_rresp, s_rdata} !== 36'h0) begin errors++;
      $display("FAIL rst_resp bresp=%b rresp=%b rdata=%h required 0", s_bresp, s_rresp, s_rdata); end
    checks++;
    if (o_regs !== exp_vec()) begin errors++; $display("FAIL rst_regs got=%h required %h", o_regs, exp_vec()); end
    checks++;
    if ({o_wr_pulse, o_rd_pulse} !== '0) begin errors++;
      $display("FAIL rst_pulses wr=%h rd=%h required 0", o_wr_pulse, o_rd_pulse); end
    reset = 1'b0;
    tick();
    checks++;
    if ({s_awready, s_wready, s_arready} !== 3'b111) begin errors++;
      $display("FAIL rst_release_ready got=%b required 111", {s_awready, s_wready, s_arready}); end
    for (int i = 0; i < NR; i++) begin
      do_read(AW'(4*i), d, r, p);
      e = (i == 15) ? (32'hC0DE_0000 + 32'(i)) : RV;
      checks++;
      if (d !== e || r !== 2'b00) begin errors++;
        $display("FAIL rst_read slot=%0d rdata=%h rresp=%b required %h 00", i, d, r, e); end
    end
  endtask

  task automatic test_write_order();
    s_awaddr = 12'h008; s_awvalid = 1'b1;
    checks++;
    if (s_awready !== 1'b1) begin errors++; $display("FAIL aw_ready_c0 got=%b required 1", s_awready); end
    tick(); s_awvalid = 1'b0;
    checks++;
    if ({s_awready, s_wready, s_bvalid} !== 3'b010) begin errors++;
      $display("FAIL aw_held_c1 aw/w/b=%b required 010", {s_awready, s_wready, s_bvalid}); end
    tick(); tick();
    s_wdata = 32'hA5A5_1234; s_wstrb = 4'hF; s_wvalid = 1'b1;
    checks++;
    if (s_bvalid !== 1'b0) begin errors++; $display("FAIL bvalid_early_c3 got=%b required 0", s_bvalid); end
    tick(); s_wvalid = 1'b0;
    exp_regs[2] = 32'hA5A5_1234;
    checks++;
    if ({s_bvalid, s_bresp} !== 3'b100 || o_regs[64 +: 32] !== 32'hA5A5_1234 || o_wr_pulse !== 16'h0004) begin errors++;
      $display("FAIL aw_first_commit bvalid=%b bresp=%b reg2=%h wr_pulse=%h required 1 00 a5a51234 0004",
               s_bvalid, s_bresp, o_regs[64 +: 32], o_wr_pulse); end
    s_bready = 1'b1; tick(); s_bready = 1'b0;
    checks++;
    if ({s_bvalid, s_awready, s_wready} !== 3'b011 || o_wr_pulse !== '0) begin errors++;
      $display("FAIL b_done b/aw/w=%b wr_pulse=%h required 011 0000", {s_bvalid, s_awready, s_wready}, o_wr_pulse); end

    s_wdata = 32'h1357_9BDF; s_wstrb = 4'hF; s_wvalid = 1'b1;
    tick(); s_wvalid = 1'b0;
    checks++;
    if ({s_awready, s_wready, s_bvalid} !== 3'b100) begin errors++;
      $display("FAIL w_held aw/w/b=%b required 100", {s_awready, s_wready, s_bvalid}); end
    tick();
    s_awaddr = 12'h00C; s_awvalid = 1'b1;
    tick(); s_awvalid = 1'b0;
    exp_regs[3] = 32'h1357_9BDF;
    checks++;
    if (s_bvalid !== 1'b1 || o_wr_pulse !== 16'h0008 || o_regs !== exp_vec()) begin errors++;
      $display("FAIL w_first_commit bvalid=%b wr_pulse=%h regs=%h required 1 0008 %h", s_bvalid, o_wr_pulse, o_regs, exp_vec()); end
    s_bready = 1'b1; tick(); s_bready = 1'b0;
  endtask

  task automatic test_wstrb();
    logic [31:0] d; logic [1:0] r; logic [NR-1:0] p;
    do_write(12'h010, 32'hFFFF_FFFF, 4'hF, r, p);
    do_write(12'h010, 32'h0000_0000, 4'b0101, r, p);
    exp_regs[4] = 32'hFF00_FF00;
    checks++;
    if (r !== 2'b00 || p !== 16'h0010) begin errors++; $display("FAIL wstrb_b bresp=%b pulses=%h required 00 0010", r, p); end
    do_read(12'h010, d, r, p);
    checks++;
    if (d !== 32'hFF00_FF00 || o_regs[128 +: 32] !== 32'hFF00_FF00) begin errors++;
      $display("FAIL wstrb_data rdata=%h reg4=%h required ff00ff00", d, o_regs[128 +: 32]); end
  endtask

  task automatic test_slverr_ro();
    logic [31:0] d; logic [1:0] r; logic [NR-1:0] p;
    do_write(12'h040, 32'h1234_5678, 4'hF, r, p);
    checks++;
    if (r !== 2'b10 || p !== '0 || o_regs !== exp_vec()) begin errors++;
      $display("FAIL oor_write bresp=%b pulses=%h regs=%h required 10 0000 %h", r, p, o_regs, exp_vec()); end
    do_read(12'h040, d, r, p);
    checks++;
    if (r !== 2'b10 || d !== 32'h0 || p !== '0) begin errors++;
      $display("FAIL oor_read rresp=%b rdata=%h pulses=%h required 10 0 0000", r, d, p); end
    do_read(12'hFFC, d, r, p);
    checks++;
    if (r !== 2'b10 || d !== 32'h0) begin errors++; $display("FAIL oor_read_top rresp=%b rdata=%h required 10 0", r, d); end
    do_read(12'h00B, d, r, p);
    checks++;
    if (r !== 2'b00 || d !== 32'hA5A5_1234 || p !== 16'h0004) begin errors++;
      $display("FAIL lsb_ignored rresp=%b rdata=%h pulses=%h required 00 a5a51234 0004", r, d, p); end
    do_write(12'h03C, 32'h9999_9999, 4'hF, r, p);
    checks++;
    if (r !== 2'b00 || p !== '0 || o_regs !== exp_vec()) begin errors++;
      $display("FAIL ro_write bresp=%b pulses=%h regs=%h required 00 0000 %h", r, p, o_regs, exp_vec()); end
    do_read(12'h03C, d, r, p);
    checks++;
    if (r !== 2'b00 || d !== 32'hC0DE_000F || p !== 16'h8000) begin errors++;
      $display("FAIL ro_read rresp=%b rdata=%h pulses=%h required 00 c0de000f 8000", r, d, p); end
  endtask

  task automatic test_stall();
    s_awaddr = 12'h014; s_wdata = 32'h5555_AAAA; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1;
    tick(); s_awvalid = 1'b0; s_wvalid = 1'b0;
    exp_regs[5] = 32'h5555_AAAA;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({s_bvalid, s_bresp, s_awready, s_wready} !== 5'b10000) begin errors++;
        $display("FAIL b_stall cyc=%0d bvalid/bresp/aw/w=%b required 10000", c, {s_bvalid, s_bresp, s_awready, s_wready}); end
      tick();
    end
    s_bready = 1'b1; tick(); s_bready = 1'b0;

    s_araddr = 12'h014; s_arvalid = 1'b1;
    tick(); s_arvalid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (s_rvalid !== 1'b1 || s_rresp !== 2'b00 || s_rdata !== 32'h5555_AAAA || s_arready !== 1'b0) begin errors++;
        $display("FAIL r_stall cyc=%0d rvalid=%b rresp=%b rdata=%h arready=%b required 1 00 5555aaaa 0",
                 c, s_rvalid, s_rresp, s_rdata, s_arready); end
      tick();
    end
    s_rready = 1'b1; tick(); s_rready = 1'b0;
    checks++;
    if (s_rvalid !== 1'b0 || s_arready !== 1'b1) begin errors++;
      $display("FAIL r_release rvalid=%b arready=%b required 0 1", s_rvalid, s_arready); end

    s_araddr = 12'h03C; s_arvalid = 1'b1;
    tick(); s_arvalid = 1'b0;
    i_ro_data[32*15 +: 32] = 32'h0BAD_F00D;
    tick(); tick();
    checks++;
    if (s_rdata !== 32'hC0DE_000F) begin errors++; $display("FAIL ro_sample rdata=%h required c0de000f", s_rdata); end
    s_rready = 1'b1; tick(); s_rready = 1'b0;
    i_ro_data[32*15 +: 32] = 32'hC0DE_000F;
  endtask

  task automatic test_same_edge();
    s_awaddr = 12'h018; s_wdata = 32'h6666_6666; s_wstrb = 4'hF; s_araddr = 12'h018;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    tick(); s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    exp_regs[6] = 32'h6666_6666;
    checks++;
    if (s_bvalid !== 1'b1 || s_rvalid !== 1'b1 || s_rdata !== RV || o_regs[192 +: 32] !== 32'h6666_6666
        || o_wr_pulse !== 16'h0040 || o_rd_pulse !== 16'h0040) begin errors++;
      $display("FAIL same_edge b=%b r=%b rdata=%h reg6=%h wr=%h rd=%h required 1 1 %h 66666666 0040 0040",
               s_bvalid, s_rvalid, s_rdata, o_regs[192 +: 32], o_wr_pulse, o_rd_pulse, RV); end
    s_bready = 1'b1; s_rready = 1'b1; tick(); s_bready = 1'b0; s_rready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int hs = 0;
    int rv = 0;
    s_araddr = 12'h008; s_arvalid = 1'b1; s_rready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (s_arvalid && s_arready) hs++;
      if (s_rvalid) rv++;
      tick();
    end
    s_arvalid = 1'b0; s_rready = 1'b0;
    tick();
    checks++;
    if (hs !== 4 || rv !== 4) begin errors++; $display("FAIL read_rate ar_hs=%0d rvalid_cycles=%0d required 4 4", hs, rv); end
  endtask

  task automatic test_reset_mid();
    s_awaddr = 12'h01C; s_awvalid = 1'b1; s_araddr = 12'h000; s_arvalid = 1'b1;
    tick(); s_awvalid = 1'b0; s_arvalid = 1'b0;
    checks++;
    if (s_awready !== 1'b0 || s_rvalid !== 1'b1) begin errors++;
      $display("FAIL mid_setup awready=%b rvalid=%b required 0 1", s_awready, s_rvalid); end
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < NR; i++) exp_regs[i] = RV;
    checks++;
    if ({s_bvalid, s_rvalid, s_awready, s_arready} !== 4'b0 || s_rdata !== 32'h0 || o_regs !== exp_vec()
        || {o_wr_pulse, o_rd_pulse} !== '0) begin errors++;
      $display("FAIL mid_reset b/r/aw/ar=%b rdata=%h regs=%h required 0000 0 %h",
               {s_bvalid, s_rvalid, s_awready, s_arready}, s_rdata, o_regs, exp_vec()); end
    @(posedge clk); #1 reset = 1'b0;
    tick();
    s_wdata = 32'h7777_7777; s_wstrb = 4'hF; s_wvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick(); s_wvalid = 1'b0;
      checks++;
      if (s_bvalid !== 1'b0 || s_rvalid !== 1'b0) begin errors++;
        $display("FAIL stale_resp cyc=%0d bvalid=%b rvalid=%b required 0 0", c, s_bvalid, s_rvalid); end
    end
    s_awaddr = 12'h01C; s_awvalid = 1'b1;
    tick(); s_awvalid = 1'b0;
    checks++;
    if (s_bvalid !== 1'b1 || o_regs[224 +: 32] !== 32'h7777_7777) begin errors++;
      $display("FAIL post_reset_write bvalid=%b reg7=%h required 1 77777777", s_bvalid, o_regs[224 +: 32]); end
    s_bready = 1'b1; tick(); s_bready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_order();
    test_wstrb();
    test_slverr_ro();
    test_stall();
    test_same_edge();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
